sync_updn_cntr: RTL and testbench
=================================

Name: sync_updn_cntr

Overview:
- Parametrised synchronous up/down counter with modulus, load, synchronous clear, and cascade terminal-count output.
- Generalises the team's 4-bit load/enable counter to any width and any modulus.
- Adds direction control, one-shot (stop-at-terminal) mode, a registered wrap pulse and a sticky overflow flag.
- Used as the counting primitive for timers, BCD digit chains and address generators.

Parameters:
- WIDTH, 8: counter width in bits, >= 2.
- MOD_MAX, (2**WIDTH)-1: terminal (maximum) count. Counter range is 0..MOD_MAX. Must satisfy 1 <= MOD_MAX <= 2**WIDTH-1.
- PRESCALE, 4: enable division ratio, >= 2. Used only when CNTR_PRESCALE_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load.
- data_in  in  WIDTH  load value.
- cnt_en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- one_shot  in  1  1 = stop at terminal; 0 = wrap.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational; used for cascading.
- wrap  out  1  one-cycle registered pulse on wrap-around.
- ovf  out  1  sticky overflow flag, registered.
- done  out  1  one-shot terminal reached, registered, held.

Behaviour:
- Reset (rstn=0, asynchronous): count=0, wrap=0, ovf=0, done=0, prescaler=0.
- Priority each rising edge: clr > load > count step > hold.
- clr: count=0, wrap=0, ovf=0, done=0, prescaler=0.
- load:
  - count = data_in, saturated to MOD_MAX when data_in > MOD_MAX.
  - done=0, wrap=0, prescaler=0; ovf is unchanged.
- Terminal value: MOD_MAX when up_dn=1; 0 when up_dn=0.
  - at_term = (count == terminal value for the current up_dn).
- step = cnt_en, additionally qualified by the prescaler (see Optional Feature).
- On step with at_term=0: count +1 when up_dn=1, -1 when up_dn=0. wrap=0.
- On step with at_term=1 and one_shot=0:
  - Up: count wraps to 0. Down: count wraps to MOD_MAX.
  - wrap=1 for exactly one cycle; ovf=1.
- On step with at_term=1 and one_shot=1: count holds, done=1, wrap=0, ovf unchanged.
- While done=1 and one_shot=1, further steps hold count.
  - done clears only via clr, load or rstn.
  - Changing up_dn while done=1 does not resume counting until load or clr.
- No step: count holds, wrap=0.
- tc = step & at_term, combinational. Feed tc to the cnt_en of the next stage for synchronous cascading.
- up_dn may change on any cycle; the new direction applies to the next step. at_term and tc reflect up_dn immediately.
- Count is never outside 0..MOD_MAX after any operation.
- Latency: count, wrap, ovf and done update on the edge that samples the qualifying inputs (one cycle). tc has zero-cycle latency.
- Reset asserted mid-count forces all registers to reset values immediately. The first post-reset step counts from 0.

Optional Feature:
- Macro: CNTR_PRESCALE_EN.
- Defined:
  - An internal prescaler counts 0..PRESCALE-1 on each cycle with cnt_en=1, and wraps.
  - step = cnt_en & (prescaler == PRESCALE-1), so count advances once per PRESCALE enabled cycles.
  - tc is qualified by the same step.
  - Prescaler is cleared by rstn, clr and load. It holds when cnt_en=0.
- Not defined: no prescaler logic; step = cnt_en; the PRESCALE parameter is ignored.

Test Plan:
- Config WIDTH=4, MOD_MAX=9, up_dn=1, one_shot=0, cnt_en=1 for 10 cycles from reset -> count 1..9 then 0; wrap=1 on the 9->0 edge only; ovf=1 afterwards; tc=1 only while count=9.
- Same config, up_dn=0 from count=0, one step -> count=9, wrap pulse, ovf=1. Then load data_in=12 -> count=9 (saturated), ovf still 1.
- one_shot=1, up_dn=1, load 7, 5 enabled cycles -> count 8, 9, 9, 9, 9; done=1 from the cycle after reaching 9; wrap never asserts. Then load 3 -> done=0, count=3.
- Simultaneous clr=1, load=1, cnt_en=1 at count=5 -> count=0. With clr=0, load=1 (data_in=2), cnt_en=1 -> count=2, no increment.
- Cascade two instances (MOD_MAX=9), with lower tc driving upper cnt_en, for 100 cycles -> upper:lower = 0:0 after 100 enables; upper increments only on lower's 9->0 edge. Assert rstn low mid-run at count 4:7 -> both stages 0 immediately.
- With CNTR_PRESCALE_EN defined and PRESCALE=4: 12 enabled cycles -> count=3. Load at prescaler=2 -> prescaler restarts, so the next increment occurs 4 enabled cycles later.

Source files
------------

// File: rtl/sync_updn_cntr.sv
// sync_updn_cntr: parametrised synchronous up/down modulus counter.
// Range 0..MOD_MAX. Features: sync clear, saturating parallel load, wrap or
// one-shot (stop at terminal) mode, registered wrap pulse, sticky overflow,
// combinational terminal count (tc) for synchronous cascading.
// Optional enable prescaler: define CNTR_PRESCALE_EN (ratio = PRESCALE).
module sync_updn_cntr #(
   parameter int WIDTH    = 8,
   parameter int MOD_MAX  = (2**WIDTH)-1,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             cnt_en,
   input  logic             up_dn,
   input  logic             one_shot,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // Elaboration-time parameter legality checks
   if (WIDTH < 2) begin : g_bad_width
      $error("sync_updn_cntr: WIDTH must be >= 2");
   end
   if (MOD_MAX < 1 || MOD_MAX > (2**WIDTH)-1) begin : g_bad_mod
      $error("sync_updn_cntr: MOD_MAX out of range");
   end
   if (PRESCALE < 2) begin : g_bad_psc
      $error("sync_updn_cntr: PRESCALE must be >= 2");
   end

   logic             at_term;
   logic             step;
   logic [WIDTH-1:0] load_val;

   // Terminal value follows the live direction, so tc reacts to up_dn at once
   assign at_term  = (count == (up_dn ? MAXV : '0));
   assign load_val = (data_in > MAXV) ? MAXV : data_in;

`ifdef CNTR_PRESCALE_EN
   localparam int            PW    = $clog2(PRESCALE);
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);

   logic [PW-1:0] psc;

   // Prescaler: advances on each enabled cycle, restarts on clr/load
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         psc <= '0;
      else if (clr || load)
         psc <= '0;
      else if (cnt_en)
         psc <= (psc == PLAST) ? '0 : psc + PW'(1);
   end

   assign step = cnt_en && (psc == PLAST);
`else
   assign step = cnt_en;
`endif

   // Cascade output: next stage advances when this one steps off its terminal
   assign tc = step && at_term;

   // Counter state: clr > load > step > hold; wrap is a one-cycle pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else if (load) begin
         count <= load_val;
         wrap  <= 1'b0;
         done  <= 1'b0;
      end else if (step) begin
         wrap <= 1'b0;
         if (done && one_shot) begin
            // parked at terminal until clr/load, regardless of direction
         end else if (!at_term) begin
            count <= up_dn ? count + ONE : count - ONE;
         end else if (!one_shot) begin
            count <= up_dn ? '0 : MAXV;
            wrap  <= 1'b1;
            ovf   <= 1'b1;
         end else begin
            done <= 1'b1;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_updn_cntr.sv
// Bench for sync_updn_cntr: a 2-stage decade cascade (WIDTH=4, MOD_MAX=9)
// driven by directed then random stimulus, plus an independent WIDTH=5,
// MOD_MAX=20 instance under random stimulus. A behavioural model tracks
// every instance; all outputs are compared against it each cycle.
module tb_sync_updn_cntr;

   localparam int W  = 4;
   localparam int MX = 9;
   localparam int W2 = 5;
   localparam int MX2 = 20;
   localparam int PS = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // cascade stimulus (shared by lower stage; upper takes clr/up_dn only)
   logic         clr = 0, load = 0, en = 0, up = 1, os = 0;
   logic [W-1:0] din = '0;
   logic [W-1:0] lo_cnt, hi_cnt;
   logic         lo_tc, lo_wrap, lo_ovf, lo_done;
   logic         hi_tc, hi_wrap, hi_ovf, hi_done;
   logic         hi_load = 1'b0, hi_os = 1'b0;
   logic [W-1:0] hi_din = '0;

   // random instance stimulus
   logic          r_clr = 0, r_load = 0, r_en = 0, r_up = 1, r_os = 0;
   logic [W2-1:0] r_din = '0;
   logic [W2-1:0] r_cnt;
   logic          r_tc, r_wrap, r_ovf, r_done;

   sync_updn_cntr #(.WIDTH(W), .MOD_MAX(MX), .PRESCALE(PS)) u_lo (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .data_in(din),
      .cnt_en(en), .up_dn(up), .one_shot(os),
      .count(lo_cnt), .tc(lo_tc), .wrap(lo_wrap), .ovf(lo_ovf), .done(lo_done));

   sync_updn_cntr #(.WIDTH(W), .MOD_MAX(MX), .PRESCALE(PS)) u_hi (
      .clk(clk), .rstn(rstn), .clr(clr), .load(hi_load), .data_in(hi_din),
      .cnt_en(lo_tc), .up_dn(up), .one_shot(hi_os),
      .count(hi_cnt), .tc(hi_tc), .wrap(hi_wrap), .ovf(hi_ovf), .done(hi_done));

   sync_updn_cntr #(.WIDTH(W2), .MOD_MAX(MX2), .PRESCALE(PS)) u_r (
      .clk(clk), .rstn(rstn), .clr(r_clr), .load(r_load), .data_in(r_din),
      .cnt_en(r_en), .up_dn(r_up), .one_shot(r_os),
      .count(r_cnt), .tc(r_tc), .wrap(r_wrap), .ovf(r_ovf), .done(r_done));

   // ---------------- behavioural model ----------------
   typedef struct {
      int cnt;
      bit wrap;
      bit ovf;
      bit done;
      int psc;
   } ms_t;

   ms_t m_lo, m_hi, m_r;
   int  tests = 0;
   int  fails = 0;

   function automatic ms_t m_zero();
      ms_t z;
      z.cnt = 0; z.wrap = 0; z.ovf = 0; z.done = 0; z.psc = 0;
      return z;
   endfunction

   function automatic bit m_step(ms_t s, bit e);
`ifdef CNTR_PRESCALE_EN
      return e && (s.psc == PS-1);
`else
      return e;
`endif
   endfunction

   function automatic bit m_tc(ms_t s, int mx, bit e, bit u);
      return m_step(s, e) && (s.cnt == (u ? mx : 0));
   endfunction

   function automatic ms_t m_next(ms_t s, int mx, bit c, bit l, int d, bit e, bit u, bit o);
      ms_t n = s;
      bit  st = m_step(s, e);
      n.wrap = 0;
      if (c) return m_zero();
      if (l) begin
         n.cnt  = (d > mx) ? mx : d;
         n.done = 0;
         n.psc  = 0;
         return n;
      end
      if (e) n.psc = (s.psc + 1) % PS;
      if (st && !(s.done && o)) begin
         if (u && s.cnt < mx)        n.cnt = s.cnt + 1;
         else if (!u && s.cnt > 0)   n.cnt = s.cnt - 1;
         else if (!o) begin
            n.cnt  = u ? 0 : mx;
            n.wrap = 1;
            n.ovf  = 1;
         end else n.done = 1;
      end
      return n;
   endfunction

   // ---------------- checking ----------------
   task automatic cmp(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model (inputs for this cycle applied)
   task automatic chk();
      cmp("lo_cnt",  int'(lo_cnt),  m_lo.cnt);
      cmp("lo_wrap", int'(lo_wrap), int'(m_lo.wrap));
      cmp("lo_ovf",  int'(lo_ovf),  int'(m_lo.ovf));
      cmp("lo_done", int'(lo_done), int'(m_lo.done));
      cmp("lo_tc",   int'(lo_tc),   int'(m_tc(m_lo, MX, en, up)));
      cmp("hi_cnt",  int'(hi_cnt),  m_hi.cnt);
      cmp("hi_wrap", int'(hi_wrap), int'(m_hi.wrap));
      cmp("hi_ovf",  int'(hi_ovf),  int'(m_hi.ovf));
      cmp("hi_tc",   int'(hi_tc),   int'(m_tc(m_hi, MX, m_tc(m_lo, MX, en, up), up)));
      cmp("r_cnt",   int'(r_cnt),   m_r.cnt);
      cmp("r_wrap",  int'(r_wrap),  int'(m_r.wrap));
      cmp("r_ovf",   int'(r_ovf),   int'(m_r.ovf));
      cmp("r_done",  int'(r_done),  int'(m_r.done));
      cmp("r_tc",    int'(r_tc),    int'(m_tc(m_r, MX2, r_en, r_up)));
   endtask

   task automatic rand_r();
      r_clr  = ($urandom_range(0, 39) == 0);
      r_load = ($urandom_range(0, 19) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) r_up = ~r_up;
      if ($urandom_range(0, 31) == 0) r_os = ~r_os;
      r_din  = W2'($urandom_range(0, 31));
   endtask

   // Called at a negedge after driving inputs: check, then advance one edge
   task automatic cyc();
      bit tlo;
      rand_r();
      #1 chk();
      @(posedge clk);
      if (!rstn) begin
         m_lo = m_zero(); m_hi = m_zero(); m_r = m_zero();
      end else begin
         tlo  = m_tc(m_lo, MX, en, up);
         m_lo = m_next(m_lo, MX, clr, load, int'(din), en, up, os);
         m_hi = m_next(m_hi, MX, clr, 1'b0, 0, tlo, up, 1'b0);
         m_r  = m_next(m_r, MX2, r_clr, r_load, int'(r_din), r_en, r_up, r_os);
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      m_lo = m_zero(); m_hi = m_zero(); m_r = m_zero();
      @(negedge clk);
      #1;
      cmp("reset_cnt",  int'(lo_cnt), 0);
      cmp("reset_ovf",  int'(lo_ovf), 0);
      cmp("reset_done", int'(r_done), 0);
      cyc();
      rstn = 1'b1;

`ifndef CNTR_PRESCALE_EN
      // count up 0..9 then wrap
      en = 1; up = 1; os = 0;
      run(9);
      #1;
      cmp("pin_cnt9", int'(lo_cnt), 9);
      cmp("pin_tc9",  int'(lo_tc), 1);
      cmp("pin_nowrap", int'(lo_wrap), 0);
      run(1);
      en = 0;
      #1;
      cmp("pin_wrap0", int'(lo_cnt), 0);
      cmp("pin_wrap",  int'(lo_wrap), 1);
      cmp("pin_ovf",   int'(lo_ovf), 1);
      cmp("pin_hi1",   int'(hi_cnt), 1);
      cmp("pin_model_ovf", int'(m_lo.ovf), 1);

      // down from 0 wraps to 9; then saturating load
      en = 1; up = 0;
      run(1);
      en = 0;
      #1;
      cmp("pin_dn_cnt",  int'(lo_cnt), 9);
      cmp("pin_dn_wrap", int'(lo_wrap), 1);
      load = 1; din = 4'd12;
      run(1);
      load = 0;
      #1;
      cmp("pin_sat", int'(lo_cnt), 9);
      cmp("pin_ovf_kept", int'(lo_ovf), 1);

      // one-shot: load 7, five steps -> 8,9,9,9,9, done held
      os = 1; up = 1; load = 1; din = 4'd7;
      run(1);
      load = 0; en = 1;
      run(5);
      #1;
      cmp("pin_os_cnt",  int'(lo_cnt), 9);
      cmp("pin_os_done", int'(lo_done), 1);
      cmp("pin_os_model", m_lo.cnt, 9);
      up = 0;
      run(2);
      #1;
      cmp("pin_os_hold", int'(lo_cnt), 9);
      en = 0; up = 1; load = 1; din = 4'd3;
      run(1);
      load = 0;
      #1;
      cmp("pin_os_reload", int'(lo_cnt), 3);
      cmp("pin_os_undone", int'(lo_done), 0);

      // priority: clr beats load beats step
      os = 0; load = 1; din = 4'd5;
      run(1);
      clr = 1; load = 1; en = 1; din = 4'd2;
      run(1);
      clr = 0;
      #1;
      cmp("pin_clr_pri", int'(lo_cnt), 0);
      run(1);
      load = 0; en = 0;
      #1;
      cmp("pin_load_pri", int'(lo_cnt), 2);

      // cascade: 100 enables return 0:0, then 47 more -> 4:7, then reset
      clr = 1;
      run(1);
      clr = 0; en = 1; up = 1;
      run(100);
      #1;
      cmp("pin_casc_lo", int'(lo_cnt), 0);
      cmp("pin_casc_hi", int'(hi_cnt), 0);
      run(47);
      #1;
      cmp("pin_47_lo", int'(lo_cnt), 7);
      cmp("pin_47_hi", int'(hi_cnt), 4);
      rstn = 0;
      m_lo = m_zero(); m_hi = m_zero(); m_r = m_zero();
      #1;
      cmp("pin_arst_lo", int'(lo_cnt), 0);
      cmp("pin_arst_hi", int'(hi_cnt), 0);
      run(2);
      rstn = 1;
      run(3);
      #1;
      cmp("pin_post_rst", int'(lo_cnt), 3);
`else
      // prescaled: 12 enables -> 3 steps; load restarts the prescaler
      en = 1; up = 1; os = 0;
      run(12);
      #1;
      cmp("pin_psc12", int'(lo_cnt), 3);
      run(2);
      load = 1; din = 4'd0;
      run(1);
      load = 0;
      run(3);
      #1;
      cmp("pin_psc_hold", int'(lo_cnt), 0);
      run(1);
      #1;
      cmp("pin_psc_step", int'(lo_cnt), 1);
`endif

      // random phase on the cascade as well
      for (int i = 0; i < 2000; i++) begin
         clr  = ($urandom_range(0, 49) == 0);
         load = ($urandom_range(0, 24) == 0);
         en   = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 15) == 0) up = ~up;
         if ($urandom_range(0, 31) == 0) os = ~os;
         din  = W'($urandom_range(0, 15));
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
